// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: memop codes,
// FSM state encoding, trap codes and store-lane helpers.
package mem_access_pkg;

    localparam int DEF_XLEN      = 64;
    localparam int DEF_MEMOP_LEN = 4;
    localparam int DEF_TRAP_LEN  = 8;

    localparam logic [DEF_MEMOP_LEN-1:0] MEMOP_NONE = 4'd0;
    localparam logic [DEF_MEMOP_LEN-1:0] MEMOP_LB   = 4'd1;
    localparam logic [DEF_MEMOP_LEN-1:0] MEMOP_LH   = 4'd2;
    localparam logic [DEF_MEMOP_LEN-1:0] MEMOP_LW   = 4'd3;
    localparam logic [DEF_MEMOP_LEN-1:0] MEMOP_LD   = 4'd4;
    localparam logic [DEF_MEMOP_LEN-1:0] MEMOP_LBU  = 4'd5;
    localparam logic [DEF_MEMOP_LEN-1:0] MEMOP_LHU  = 4'd6;
    localparam logic [DEF_MEMOP_LEN-1:0] MEMOP_LWU  = 4'd7;
    localparam logic [DEF_MEMOP_LEN-1:0] MEMOP_SB   = 4'd8;
    localparam logic [DEF_MEMOP_LEN-1:0] MEMOP_SH   = 4'd9;
    localparam logic [DEF_MEMOP_LEN-1:0] MEMOP_SW   = 4'd10;
    localparam logic [DEF_MEMOP_LEN-1:0] MEMOP_SD   = 4'd11;

    localparam logic [DEF_TRAP_LEN-1:0] TRAP_NONE           = 8'd0;
    localparam logic [DEF_TRAP_LEN-1:0] TRAP_LOAD_MISALIGN  = 8'd4;
    localparam logic [DEF_TRAP_LEN-1:0] TRAP_STORE_MISALIGN = 8'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // One data-memory request as held stable on the bus
    typedef struct packed {
        logic [DEF_XLEN-1:0] addr;
        logic                wen;
        logic [DEF_XLEN-1:0] wdata;
        logic [7:0]          wmask;
    } mem_req_t;

    function automatic logic is_load(input logic [DEF_MEMOP_LEN-1:0] op);
        return (op >= MEMOP_LB) && (op <= MEMOP_LWU);
    endfunction

    function automatic logic is_store(input logic [DEF_MEMOP_LEN-1:0] op);
        return (op >= MEMOP_SB) && (op <= MEMOP_SD);
    endfunction

    function automatic logic [7:0] store_mask(
        input logic [DEF_MEMOP_LEN-1:0] op,
        input logic [2:0]               off
    );
        logic [7:0] m;
        case (op)
            MEMOP_SB: m = 8'h01 << off;
            MEMOP_SH: m = 8'h03 << off;
            MEMOP_SW: m = 8'h0F << off;
            MEMOP_SD: m = 8'hFF;
            default:  m = 8'h00;
        endcase
        return m;
    endfunction

    // Access size not naturally aligned within the doubleword
    function automatic logic misaligned(
        input logic [DEF_MEMOP_LEN-1:0] op,
        input logic [2:0]               off
    );
        logic r;
        case (op)
            MEMOP_LH, MEMOP_LHU, MEMOP_SH: r = off[0];
            MEMOP_LW, MEMOP_LWU, MEMOP_SW: r = |off[1:0];
            MEMOP_LD, MEMOP_SD:            r = |off;
            default:                       r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load data extraction: shifts the addressed lane of a full doubleword
// down to bit 0 and sign/zero-extends it according to the memop.
module mem_load_align
    import mem_access_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int MEMOP_LEN = DEF_MEMOP_LEN
) (
    input  logic [XLEN-1:0]      rdata_i,
    input  logic [2:0]           off_i,
    input  logic [MEMOP_LEN-1:0] memop_i,
    output logic [XLEN-1:0]      data_o
);

    logic [XLEN-1:0] d;

    // Lane shift followed by width-dependent extension
    always_comb begin
        d = rdata_i >> {off_i, 3'b000};
        case (memop_i)
            MEMOP_LB:  data_o = {{(XLEN-8){d[7]}}, d[7:0]};
            MEMOP_LH:  data_o = {{(XLEN-16){d[15]}}, d[15:0]};
            MEMOP_LW:  data_o = {{(XLEN-32){d[31]}}, d[31:0]};
            MEMOP_LBU: data_o = {{(XLEN-8){1'b0}}, d[7:0]};
            MEMOP_LHU: data_o = {{(XLEN-16){1'b0}}, d[15:0]};
            MEMOP_LWU: data_o = {{(XLEN-32){1'b0}}, d[31:0]};
            default:   data_o = d;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: one load/store per instruction over a req/rsp
// port, registered result to writeback. Option: MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int XLEN      = DEF_XLEN,
    parameter int MEMOP_LEN = DEF_MEMOP_LEN,
    parameter int TRAP_LEN  = DEF_TRAP_LEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [31:0]          in_inst,
    input  logic [4:0]           in_rd_idx,
    input  logic [XLEN-1:0]      in_alu_out,
    input  logic [XLEN-1:0]      in_rs2_data,
    input  logic [MEMOP_LEN-1:0] in_memop,
    input  logic [TRAP_LEN-1:0]  in_trap,
    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [XLEN-1:0]      mem_addr,
    output logic                 mem_wen,
    output logic [XLEN-1:0]      mem_wdata,
    output logic [7:0]           mem_wmask,
    input  logic                 mem_rsp_valid,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_pc,
    output logic [31:0]          out_inst,
    output logic [4:0]           out_rd_idx,
    output logic [XLEN-1:0]      out_result,
    output logic [TRAP_LEN-1:0]  out_trap
);

    state_e state_q, state_d;

    logic [XLEN-1:0]      pc_q, alu_q;
    logic [31:0]          inst_q;
    logic [4:0]           rd_q;
    logic [MEMOP_LEN-1:0] memop_q;

    mem_req_t req_q, req_d;

    logic                out_valid_q, out_valid_d;
    logic [XLEN-1:0]     out_pc_q, out_pc_d;
    logic [31:0]         out_inst_q, out_inst_d;
    logic [4:0]          out_rd_q, out_rd_d;
    logic [XLEN-1:0]     out_result_q, out_result_d;
    logic [TRAP_LEN-1:0] out_trap_q, out_trap_d;

    logic                capture, pass, is_mem, mis, out_load;
    logic [2:0]          off_in;
    logic [TRAP_LEN-1:0] pass_trap;
    logic [XLEN-1:0]     ld_data;

    // Classify the incoming instruction: bus access or straight pass-through
    always_comb begin
        off_in = in_alu_out[2:0];
        is_mem = is_load(in_memop) || is_store(in_memop);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        mis = misaligned(in_memop, off_in);
`else
        mis = 1'b0;
`endif
        pass = !is_mem || (in_trap != '0) || mis;
        if (in_trap != '0)
            pass_trap = in_trap;
        else if (mis)
            pass_trap = is_load(in_memop) ? TRAP_LOAD_MISALIGN
                                          : TRAP_STORE_MISALIGN;
        else
            pass_trap = '0;
        capture = in_valid && in_ready;
    end

    mem_load_align #(
        .XLEN      (XLEN),
        .MEMOP_LEN (MEMOP_LEN)
    ) u_load_align (
        .rdata_i (mem_rdata),
        .off_i   (alu_q[2:0]),
        .memop_i (memop_q),
        .data_o  (ld_data)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state; responses only count while waiting for one
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (capture && !pass) state_d = ST_REQ;
            ST_REQ:  if (mem_req_ready)    state_d = ST_WAIT;
            ST_WAIT: if (mem_rsp_valid)    state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: handshakes and next values of the output register
    always_comb begin
        mem_req_valid = (state_q == ST_REQ);
        in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);

        req_d.addr  = {in_alu_out[XLEN-1:3], 3'b000};
        req_d.wen   = is_store(in_memop);
        req_d.wdata = is_store(in_memop)
                    ? in_rs2_data << {off_in, 3'b000} : '0;
        req_d.wmask = store_mask(in_memop, off_in);

        out_load     = 1'b0;
        out_pc_d     = out_pc_q;
        out_inst_d   = out_inst_q;
        out_rd_d     = out_rd_q;
        out_result_d = out_result_q;
        out_trap_d   = out_trap_q;
        if (capture && pass) begin
            out_load     = 1'b1;
            out_pc_d     = in_pc;
            out_inst_d   = in_inst;
            out_rd_d     = in_rd_idx;
            out_result_d = in_alu_out;
            out_trap_d   = pass_trap;
        end else if (state_q == ST_WAIT && mem_rsp_valid) begin
            out_load     = 1'b1;
            out_pc_d     = pc_q;
            out_inst_d   = inst_q;
            out_rd_d     = rd_q;
            out_result_d = is_load(memop_q) ? ld_data : alu_q;
            out_trap_d   = '0;
        end

        if (out_load)       out_valid_d = 1'b1;
        else if (out_ready) out_valid_d = 1'b0;
        else                out_valid_d = out_valid_q;
    end

    // Latch the instruction fields and bus request at capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            inst_q  <= '0;
            rd_q    <= '0;
            alu_q   <= '0;
            memop_q <= MEMOP_NONE;
            req_q   <= '0;
        end else if (capture) begin
            pc_q    <= in_pc;
            inst_q  <= in_inst;
            rd_q    <= in_rd_idx;
            alu_q   <= in_alu_out;
            memop_q <= in_memop;
            if (!pass) req_q <= req_d;
        end
    end

    // Writeback output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_inst_q   <= '0;
            out_rd_q     <= '0;
            out_result_q <= '0;
            out_trap_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_inst_q   <= out_inst_d;
            out_rd_q     <= out_rd_d;
            out_result_q <= out_result_d;
            out_trap_q   <= out_trap_d;
        end
    end

    assign mem_addr   = req_q.addr;
    assign mem_wen    = req_q.wen;
    assign mem_wdata  = req_q.wdata;
    assign mem_wmask  = req_q.wmask;
    assign out_valid  = out_valid_q;
    assign out_pc     = out_pc_q;
    assign out_inst   = out_inst_q;
    assign out_rd_idx = out_rd_q;
    assign out_result = out_result_q;
    assign out_trap   = out_trap_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: vector table plus stall/backpressure/
// reset sequences. Honors MEM_ACCESS_MISALIGN_TRAP_EN if defined.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [63:0] in_pc, in_alu_out, in_rs2_data;
    logic [31:0] in_inst;
    logic [4:0]  in_rd_idx;
    logic [3:0]  in_memop;
    logic [7:0]  in_trap;
    logic        mem_req_valid, mem_req_ready;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wen;
    logic [7:0]  mem_wmask;
    logic        mem_rsp_valid;
    logic        out_valid, out_ready;
    logic [63:0] out_pc, out_result;
    logic [31:0] out_inst;
    logic [4:0]  out_rd_idx;
    logic [7:0]  out_trap;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_access dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_pc         (in_pc),
        .in_inst       (in_inst),
        .in_rd_idx     (in_rd_idx),
        .in_alu_out    (in_alu_out),
        .in_rs2_data   (in_rs2_data),
        .in_memop      (in_memop),
        .in_trap       (in_trap),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_inst      (out_inst),
        .out_rd_idx    (out_rd_idx),
        .out_result    (out_result),
        .out_trap      (out_trap)
    );

    typedef struct {
        logic [3:0]  memop;
        logic [63:0] alu;
        logic [63:0] rs2;
        logic [63:0] rdata;
        logic [7:0]  trap;
        logic        req;
        logic [63:0] addr;
        logic        wen;
        logic [7:0]  wmask;
        logic [63:0] wdata;
        logic [63:0] result;
        logic [7:0]  otrap;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(
        input logic [3:0] memop, input logic [63:0] alu,
        input logic [63:0] rs2, input logic [63:0] rdata,
        input logic [7:0] trap, input logic req,
        input logic [63:0] addr, input logic wen,
        input logic [7:0] wmask, input logic [63:0] wdata,
        input logic [63:0] result, input logic [7:0] otrap
    );
        vec_t v;
        v.memop = memop; v.alu = alu; v.rs2 = rs2;
        v.rdata = rdata; v.trap = trap; v.req = req;
        v.addr = addr; v.wen = wen; v.wmask = wmask;
        v.wdata = wdata; v.result = result; v.otrap = otrap;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [63:0] alu,
                         input logic [63:0] rs2, input logic [7:0] trap,
                         input int tag);
        in_valid    = 1'b1;
        in_memop    = op;
        in_alu_out  = alu;
        in_rs2_data = rs2;
        in_trap     = trap;
        in_pc       = 64'h1000 + 64'(tag) * 4;
        in_inst     = 32'h13 + 32'(tag);
        in_rd_idx   = 5'(tag);
    endtask

    task automatic run_vec(input vec_t v, input int i);
        tick();
        chk($sformatf("v%0d.in_ready", i), in_ready, 1);
        drive(v.memop, v.alu, v.rs2, v.trap, i);
        out_ready = 1'b1;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        tick();
        in_valid = 1'b0;
        if (v.req) begin
            chk($sformatf("v%0d.req_valid", i), mem_req_valid, 1);
            chk($sformatf("v%0d.addr", i), mem_addr, v.addr);
            chk($sformatf("v%0d.wen", i), mem_wen, v.wen);
            if (v.wen) begin
                chk($sformatf("v%0d.wmask", i), mem_wmask, v.wmask);
                chk($sformatf("v%0d.wdata", i), mem_wdata, v.wdata);
            end
            chk($sformatf("v%0d.early_out", i), out_valid, 0);
            tick();
            chk($sformatf("v%0d.req_drop", i), mem_req_valid, 0);
            mem_rsp_valid = 1'b1;
            mem_rdata = v.rdata;
            tick();
            mem_rsp_valid = 1'b0;
        end else begin
            chk($sformatf("v%0d.no_req", i), mem_req_valid, 0);
        end
        chk($sformatf("v%0d.out_valid", i), out_valid, 1);
        chk($sformatf("v%0d.result", i), out_result, v.result);
        chk($sformatf("v%0d.trap", i), out_trap, v.otrap);
        chk($sformatf("v%0d.pc", i), out_pc, 64'h1000 + 64'(i) * 4);
        chk($sformatf("v%0d.rd", i), out_rd_idx, 64'(i[4:0]));
    endtask

    initial begin
        tv.push_back(mk(4'd0, 64'h1234, 0, 0, 0, 0, 0, 0, 0, 0,
                        64'h1234, 0));
        tv.push_back(mk(4'd1, 64'h80000003, 0, 64'h0000000080000000, 0,
                        1, 64'h80000000, 0, 0, 0,
                        64'hFFFFFFFFFFFFFF80, 0));
        tv.push_back(mk(4'd5, 64'h80000003, 0, 64'h0000000080000000, 0,
                        1, 64'h80000000, 0, 0, 0, 64'h80, 0));
        tv.push_back(mk(4'd9, 64'h80000006, 64'hABCD, 0, 0,
                        1, 64'h80000000, 1, 8'hC0, 64'hABCD000000000000,
                        64'h80000006, 0));
        tv.push_back(mk(4'd2, 64'h80000012, 0, 64'h0000000080010000, 0,
                        1, 64'h80000010, 0, 0, 0,
                        64'hFFFFFFFFFFFF8001, 0));
        tv.push_back(mk(4'd6, 64'h80000012, 0, 64'h0000000080010000, 0,
                        1, 64'h80000010, 0, 0, 0, 64'h8001, 0));
        tv.push_back(mk(4'd3, 64'h2004, 0, 64'h8765432100000000, 0,
                        1, 64'h2000, 0, 0, 0, 64'hFFFFFFFF87654321, 0));
        tv.push_back(mk(4'd7, 64'h2004, 0, 64'h8765432100000000, 0,
                        1, 64'h2000, 0, 0, 0, 64'h87654321, 0));
        tv.push_back(mk(4'd4, 64'h1000, 0, 64'h0123456789ABCDEF, 0,
                        1, 64'h1000, 0, 0, 0, 64'h0123456789ABCDEF, 0));
        tv.push_back(mk(4'd8, 64'h2005, 64'h11223344, 0, 0,
                        1, 64'h2000, 1, 8'h20, 64'h2233440000000000,
                        64'h2005, 0));
        tv.push_back(mk(4'd10, 64'h3004, 64'hDEADBEEF, 0, 0,
                        1, 64'h3000, 1, 8'hF0, 64'hDEADBEEF00000000,
                        64'h3004, 0));
        tv.push_back(mk(4'd11, 64'h4008, 64'hCAFEF00D12345678, 0, 0,
                        1, 64'h4008, 1, 8'hFF, 64'hCAFEF00D12345678,
                        64'h4008, 0));
        tv.push_back(mk(4'd1, 64'h3003, 0, 0, 8'd2, 0, 0, 0, 0, 0,
                        64'h3003, 8'd2));
        tv.push_back(mk(4'd15, 64'h55, 0, 0, 0, 0, 0, 0, 0, 0,
                        64'h55, 0));
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        tv.push_back(mk(4'd3, 64'h80000002, 0, 64'hFFFF000012345678, 0,
                        0, 0, 0, 0, 0, 64'h80000002, 8'd4));
        tv.push_back(mk(4'd11, 64'h4001, 64'h1122334455667788, 0, 0,
                        0, 0, 0, 0, 0, 64'h4001, 8'd6));
`else
        tv.push_back(mk(4'd3, 64'h80000002, 0, 64'hFFFF000012345678, 0,
                        1, 64'h80000000, 0, 0, 0, 64'h1234, 0));
        tv.push_back(mk(4'd11, 64'h4001, 64'h1122334455667788, 0, 0,
                        1, 64'h4000, 1, 8'hFF, 64'h2233445566778800,
                        64'h4001, 0));
`endif
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        drive(4'd0, 0, 0, 0, 0);
        in_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata = '0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst.req_valid", mem_req_valid, 0);
        chk("rst.addr", mem_addr, 0);
        chk("rst.wen", mem_wen, 0);
        chk("rst.wmask", mem_wmask, 0);
        chk("rst.wdata", mem_wdata, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.result", out_result, 0);
        chk("rst.in_ready", in_ready, 1);
        rst_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) run_vec(tv[i], i);

        // LD with 3 request stall cycles and a 2-cycle response wait
        tick();
        drive(4'd4, 64'h80000010, 0, 0, 20);
        mem_req_ready = 1'b0;
        mem_rdata = 64'hDEAD;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("ld.c%0d.req_valid", k), mem_req_valid,
                64'(k <= 3));
            if (k <= 3) begin
                chk($sformatf("ld.c%0d.addr", k), mem_addr, 64'h80000010);
                chk($sformatf("ld.c%0d.wen", k), mem_wen, 0);
            end
            chk($sformatf("ld.c%0d.out_valid", k), out_valid, 0);
            chk($sformatf("ld.c%0d.in_ready", k), in_ready, 0);
            mem_req_ready = (k == 3);
            mem_rsp_valid = (k == 1) || (k == 5);
            if (k == 5) begin
                mem_rdata = 64'hFEDCBA9876543210;
                out_ready = 1'b0;
                drive(4'd0, 64'h77, 0, 0, 21);
            end
            tick();
        end
        mem_rsp_valid = 1'b0;
        chk("ld.out_valid", out_valid, 1);
        chk("ld.result", out_result, 64'hFEDCBA9876543210);
        chk("ld.pc", out_pc, 64'h1000 + 20 * 4);

        // Writeback backpressure for 4 cycles, then back-to-back refill
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("bp.c%0d.out_valid", j), out_valid, 1);
            chk($sformatf("bp.c%0d.result", j), out_result,
                64'hFEDCBA9876543210);
            chk($sformatf("bp.c%0d.in_ready", j), in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("bp.refill_valid", out_valid, 1);
        chk("bp.refill_result", out_result, 64'h77);
        tick();
        chk("bp.drain", out_valid, 0);

        // Reset while a request is pending drops it at once
        drive(4'd4, 64'h500, 0, 0, 22);
        mem_req_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        chk("rreq.req_valid", mem_req_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("rreq.req_drop", mem_req_valid, 0);
        tick();
        rst_n = 1'b1;

        // Reset while waiting for a response; stray rsp afterwards ignored
        drive(4'd1, 64'h100, 0, 0, 23);
        mem_req_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("rwait.req_valid", mem_req_valid, 1);
        tick();
        chk("rwait.in_wait", mem_req_valid, 0);
        rst_n = 1'b0;
        #1;
        chk("rwait.req_valid0", mem_req_valid, 0);
        chk("rwait.out_valid0", out_valid, 0);
        tick();
        rst_n = 1'b1;
        mem_rsp_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            chk($sformatf("stray.c%0d.out_valid", k), out_valid, 0);
            chk($sformatf("stray.c%0d.req_valid", k), mem_req_valid, 0);
            chk($sformatf("stray.c%0d.in_ready", k), in_ready, 1);
        end
        mem_rsp_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage directly downstream of execute; consumes its ALU result, rs2 data, memop, rd index, pc, inst and trap fields.
- Issues one load/store per instruction to the data-memory port over a request/response handshake.
- Aligns store data and byte mask; extracts and sign/zero-extends load data.
- Presents a registered result to writeback with a valid/ready handshake; non-memory instructions pass through.

Parameters:
- XLEN, 64, datapath width; must equal `XLEN.
- MEMOP_LEN, 4, memop code width; must equal `MEMOP_LEN.
- TRAP_LEN, 8, trap code width; must equal `TRAP_BUS width; 0 means no trap.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute result valid
- in_ready  out  1  stage can accept
- in_pc / in_inst  in  XLEN / 32  pass-through
- in_rd_idx  in  5  destination register
- in_alu_out  in  XLEN  address (mem ops) or result
- in_rs2_data  in  XLEN  store data
- in_memop  in  MEMOP_LEN  memory op code
- in_trap  in  TRAP_LEN  upstream trap
- mem_req_valid  out  1  request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  XLEN  8-byte-aligned address
- mem_wen  out  1  1=store
- mem_wdata  out  XLEN  lane-shifted store data
- mem_wmask  out  8  byte enables
- mem_rsp_valid  in  1  read data / write ack
- mem_rdata  in  XLEN  read data, full doubleword
- out_valid  out  1  writeback entry valid
- out_ready  in  1  writeback accepts
- out_pc / out_inst / out_rd_idx  out  XLEN / 32 / 5  pass-through
- out_result  out  XLEN  load data or in_alu_out
- out_trap  out  TRAP_LEN  trap code

Behaviour:
- Reset: state=IDLE; mem_req_valid=0; mem_wen=0; mem_addr=0; mem_wdata=0; mem_wmask=0; out_valid=0; all other out_* registers=0.
- in_ready=1 only in IDLE when (!out_valid || out_ready). Capture occurs on in_valid & in_ready; fields are latched.
- FSM has states IDLE, REQ, WAIT.
- IDLE transitions:
  - Non-mem op, or in_trap!=0: output register loaded at capture edge; out_valid=1 next cycle (latency 1); no bus activity.
  - Mem op: go to REQ.
- REQ: mem_req_valid=1; addr/wen/wdata/wmask held stable until mem_req_ready; on the handshake go to WAIT.
- WAIT: mem_rsp_valid is sampled only in WAIT; rsp in REQ is ignored. On rsp, load the output register (out_valid=1 next cycle) and return to IDLE.
- Mem latency = 1 + request stall cycles + response cycles.
- Output: out_valid held with all out_* stable until out_ready; clears on out_valid & out_ready unless refilled the same edge (back-to-back allowed).
- Address and store data:
  - off = in_alu_out[2:0]; mem_addr = {in_alu_out[XLEN-1:3], 3'b0}.
  - Store mask: SB=8'h01<<off, SH=8'h03<<off, SW=8'h0F<<off, SD=8'hFF.
  - mem_wdata = in_rs2_data << (off*8), truncated to XLEN.
- Load extraction: d = mem_rdata >> (off*8); LB/LH/LW sign-extend d[7:0]/[15:0]/[31:0]; LBU/LHU/LWU zero-extend; LD = d.
- Store writeback: out_result = in_alu_out. Stores and traps do not write rd; downstream gates on memop/trap.
- Memop codes: NONE=0, LB, LH, LW, LD, LBU, LHU, LWU, SB, SH, SW, SD. Unknown codes are treated as NONE.
- Reset mid-operation returns the FSM to IDLE and drops mem_req_valid immediately. The memory side must tolerate an abandoned request; a late rsp in IDLE is ignored.

Optional Feature:
- Macro: MEM_ACCESS_MISALIGN_TRAP_EN.
- Defined: LH/LHU with off[0]!=0, LW/LWU with off[1:0]!=0, LD with off!=0 (and likewise SH/SW/SD) issue no bus request. The instruction passes through with latency 1, out_trap=4 for loads and 6 for stores.
- Undefined: no check; lanes whose shift exceeds the doubleword are truncated silently.

Decomposition:
- Shared package: MEMOP_* codes, MEMOP_LEN, FSM state encoding, trap codes TRAP_LOAD_MISALIGN=4 and TRAP_STORE_MISALIGN=6.
- One sub-module, mem_load_align: combinational rdata shift plus sign/zero extension, reused by writeback/difftest.

Test Plan:
- ADDI result 0x1234, memop NONE, out_ready=1 -> out_valid one cycle after capture, out_result=0x1234, no mem_req_valid.
- LB addr 0x80000003, mem_rdata=0x00000000_80000000 -> mem_addr 0x80000000, out_result 0xFFFFFFFFFFFFFF80; same with LBU -> 0x80.
- SH addr 0x80000006, rs2=0xABCD -> mem_wen=1, mem_wmask=0xC0, mem_wdata=0xABCD000000000000.
- LD with mem_req_ready low 3 cycles, rsp 2 cycles later -> request fields stable throughout; out_valid 6 cycles after capture; in_ready=0 meanwhile.
- out_ready=0 for 4 cycles with a completed load -> out_* stable, in_ready=0; release -> next instruction captured the same edge.
- Reset asserted in WAIT -> mem_req_valid/out_valid 0 immediately; a subsequent stray mem_rsp_valid is ignored. With macro defined, LW at 0x...2 -> no request, out_trap=4.
